// File: rtl/ram.sv
// Dual-port I/Q sample RAM, read-first, one write and one read per cycle.
// Optional second output register stage selected by RAM_OUT_REG_EN.
module ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] isub_i,
  input  logic signed [DATA_W-1:0] isub_q,
  input  logic        [ADDR_W-1:0] count_w,
  input  logic        [ADDR_W-1:0] count_r,
  output logic signed [DATA_W-1:0] osub_i,
  output logic signed [DATA_W-1:0] osub_q
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int WORD_W = 2 * DATA_W;

  logic [WORD_W-1:0] mem [0:DEPTH-1];
  logic [WORD_W-1:0] rd_q;

  // Write port: {I, Q} every cycle, suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[count_w] <= {isub_i, isub_q};
    end
  end

  // Read port: registered, sees pre-write contents on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[count_r];
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [WORD_W-1:0] out_q;

  // Second output stage, cleared together with the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign osub_i = out_q[WORD_W-1:DATA_W];
  assign osub_q = out_q[DATA_W-1:0];
`else
  assign osub_i = rd_q[WORD_W-1:DATA_W];
  assign osub_q = rd_q[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset, read-first, wrap, sign, delay line.
// Read latency follows RAM_OUT_REG_EN so either build can be checked.
module tb_ram;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk;
  logic               rst;
  logic signed [11:0] isub_i;
  logic signed [11:0] isub_q;
  logic        [13:0] count_w;
  logic        [13:0] count_r;
  logic signed [11:0] osub_i;
  logic signed [11:0] osub_q;

  int total = 0;
  int bad = 0;

  bit                 p_en  [2];
  logic signed [11:0] p_i   [2];
  logic signed [11:0] p_q   [2];
  string              p_tag [2];

  ram #(.ADDR_W(14), .DATA_W(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .isub_i  (isub_i),
    .isub_q  (isub_q),
    .count_w (count_w),
    .count_r (count_r),
    .osub_i  (osub_i),
    .osub_q  (osub_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string              tag,
    input logic signed [11:0] obs,
    input logic signed [11:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle; the expected read result is queued
  // and checked when it reaches the output LAT edges later.
  task automatic step(
    input logic               r,
    input logic        [13:0] wa,
    input logic signed [11:0] wi,
    input logic signed [11:0] wq,
    input logic        [13:0] ra,
    input bit                 en,
    input logic signed [11:0] ei,
    input logic signed [11:0] eq,
    input string              tag
  );
    rst = r;
    count_w = wa;
    isub_i = wi;
    isub_q = wq;
    count_r = ra;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        p_en[k] = 1'b1;
        p_i[k] = '0;
        p_q[k] = '0;
        p_tag[k] = {tag, "_rst"};
      end
    end else begin
      p_en[1] = p_en[0];
      p_i[1] = p_i[0];
      p_q[1] = p_q[0];
      p_tag[1] = p_tag[0];
      p_en[0] = en;
      p_i[0] = ei;
      p_q[0] = eq;
      p_tag[0] = tag;
    end
    if (p_en[LAT-1]) begin
      chk({p_tag[LAT-1], "_i"}, osub_i, p_i[LAT-1]);
      chk({p_tag[LAT-1], "_q"}, osub_q, p_q[LAT-1]);
    end
  endtask

  initial begin
    logic signed [11:0] v;
    logic signed [11:0] e;
    rst = 1'b1;
    isub_i = '0;
    isub_q = '0;
    count_w = '0;
    count_r = '0;
    for (int k = 0; k < 2; k++) begin
      p_en[k] = 1'b0;
      p_i[k] = '0;
      p_q[k] = '0;
      p_tag[k] = "";
    end

    // reset held with live inputs
    for (int k = 0; k < 3; k++)
      step(1, 14'd5, 12'sh3A5, 12'sh5C3,
           14'd5, 0, 0, 0, "reset");

    // write after reset, read back
    step(0, 14'd5, 12'sh7FF, 12'sh800,
         14'd7, 0, 0, 0, "");
    step(0, 14'd100, 0, 0,
         14'd5, 1, 12'sh7FF, 12'sh800, "post_rst");

    // read during write returns old data
    step(0, 14'd9, 12'sh123, 12'sh0AB,
         14'd200, 0, 0, 0, "");
    step(0, 14'd9, 12'sh456, 12'sh0CD,
         14'd9, 1, 12'sh123, 12'sh0AB, "rdw_old");
    step(0, 14'd100, 0, 0,
         14'd9, 1, 12'sh456, 12'sh0CD, "rdw_new");

    // sign and width
    step(0, 14'd20, 12'sh800, 12'sh001,
         14'd0, 0, 0, 0, "");
    step(0, 14'd100, 0, 0,
         14'd20, 1, 12'sh800, 12'sh001, "sign");

    // address extremes
    step(0, 14'd16383, 12'sh111, 12'sh222,
         14'd0, 0, 0, 0, "");
    step(0, 14'd0, 12'sh333, 12'sh444,
         14'd16383, 1, 12'sh111, 12'sh222, "wrap_hi");
    step(0, 14'd100, 0, 0,
         14'd0, 1, 12'sh333, 12'sh444, "wrap_lo");

    // delay line, shift 4, rst pulse at n=19
    for (int n = 0; n < 24; n++) begin
      v = 12'(n);
      e = 12'(n - 4);
      step((n == 19), 14'(n), v, -v,
           14'(n) - 14'd4,
           (n >= 4) && (n != 23),
           e, -e, "dline");
    end

    // data written before the rst pulse survives
    step(0, 14'd100, 0, 0,
         14'd3, 1, 12'sh003, -12'sh003, "keep3");
    step(0, 14'd100, 0, 0,
         14'd18, 1, 12'sh012, -12'sh012, "keep18");
    step(0, 14'd100, 0, 0,
         14'd0, 0, 0, 0, "flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
